fetch_decode_unit: RTL and testbench
====================================

// Module: fetch_decode_unit
// PURPOSE
//  Parametrised RV32I front end: fetches from a sync-read instruction RAM,
//  buffers words in a prefetch FIFO and decodes full-format fields (R/I/S/B/U/J).
//  Adds fetch-address flush on redirect and a valid/ready output handshake.
//  Sits between the IMEM dual_port_ram port B and the core execute stage.
// PARAMETERS
//  IMEM_SIZE   4096   IMEM depth in 32-bit words, power of 2; AW = $clog2(IMEM_SIZE)
//  FIFO_DEPTH  4      prefetch FIFO entries, power of 2, >= 2
//  RESET_PC    32'h0  fetch PC after reset, word aligned
// PORTS
//  clk             in   1   clock
//  reset           in   1   synchronous, active-low reset (0 = reset)
//  imem_en         out  1   read request this cycle
//  imem_addr       out  AW  word address = fetch_pc[AW+1:2]
//  imem_rdata      in   32  read data, valid exactly 1 cycle after imem_en
//  redirect_valid  in   1   flush and restart fetch
//  redirect_pc     in   32  new PC; bits [1:0] ignored (forced 0)
//  out_valid       out  1   decoded instruction available
//  out_ready       in   1   consumer accepts (pop when valid & ready)
//  out_pc          out  32  PC of instruction
//  out_instr       out  32  raw instruction word
//  out_opcode      out  7   instr[6:0]
//  out_rd/rs1/rs2  out  5   instr[11:7] / [19:15] / [24:20]
//  out_funct3      out  3   instr[14:12]
//  out_funct7      out  7   instr[31:25]
//  out_fmt         out  3   0=R 1=I 2=S 3=B 4=U 5=J 7=illegal
//  out_imm         out  32  sign-extended immediate per fmt; 0 for R/illegal
//  out_illegal     out  1   opcode not in RV32I base set
// BEHAVIOUR
//  Reset (reset=0): fetch_pc=RESET_PC, FIFO empty, inflight=0; imem_en=0,
//   out_valid=0, all out_* = 0. Any response for a pre-reset request is discarded.
//  Issue: imem_en=1 when reset=1, redirect_valid=0, and
//   count + inflight - pop < FIFO_DEPTH (pop = out_valid & out_ready).
//   On issue: inflight<=1, pc_q<=fetch_pc, fetch_pc<=fetch_pc+4.
//  Response: cycle after issue, {pc_q, imem_rdata, decoded fields} pushed to FIFO;
//   never dropped for lack of space (credit rule guarantees it).
//  Output: head of FIFO; out_valid = !empty. Fields held stable while
//   valid & !ready. Push and pop in the same cycle allowed at any occupancy.
//  Throughput: 1 instr/cycle sustained while out_ready=1.
//  Latency: first-issue cycle T -> FIFO write end of T+1 -> out_valid in T+2.
//   First cycle with reset=1 issues RESET_PC.
//  Redirect (cycle N): a pop in N completes first; then FIFO cleared, response
//   arriving in N discarded, imem_en=0 in N, fetch_pc<=redirect_pc.
//   redirect_pc is issued in N+1, out_valid in N+3. Redirect while empty is identical.
//  Wrap: fetch_pc is a 32-bit +4 counter wrapping at 2^32; imem_addr wraps modulo
//   IMEM_SIZE; out_pc keeps the full 32-bit value.
//  Decode (registered at push): opcodes 0110011 R; 0010011, 0000011, 1100111, 1110011,
//   0001111 I; 0100011 S; 1100011 B; 0110111, 0010111 U; 1101111 J; else fmt=7,
//   illegal=1. The word is still delivered (no exception raised here).
//  Immediates: I {{20{i[31]}},i[31:20]}; S {{20{i[31]}},i[31:25],i[11:7]};
//   B {{19{i[31]}},i[31],i[7],i[30:25],i[11:8],0};
//   U {i[31:12],12'b0}; J {{11{i[31]}},i[31],i[19:12],i[20],i[30:21],0}.
// TESTING
//  1. RESET_PC=0, IMEM[0]=32'h00500093, out_ready=1 -> out_valid at cycle 2,
//     pc=0, fmt=1, rd=1, imm=5.
//  2. out_ready=0 for 10 cycles, FIFO_DEPTH=4 -> imem_en stops after 4 issues,
//     head stable; then ready=1 -> pcs 0,4,8,12,16 in order, one per cycle.
//  3. FIFO full, redirect_pc=32'h43 -> no stale words; next out_pc=32'h40,
//     3 cycles after redirect.
//  4. IMEM word 32'hFE000CE3 -> fmt=3, imm=32'hFFFFFFF8; word 32'h0000007F ->
//     illegal=1, fmt=7, imm=0.
//  5. IMEM_SIZE=16, start pc=32'h38 -> imem_addr 14,15,0,1;
//     out_pc 32'h38, 32'h3C, 32'h40, 32'h44.
//  6. reset=0 in the cycle after an issue -> no push, out_valid=0 until
//     refetch from RESET_PC.

Source files
------------

// File: rtl/fetch_decode_if.sv
// Handshake/bus bundle between the fetch/decode front end, the IMEM read port
// and the execute-stage consumer.
interface fetch_decode_if #(parameter int AW = 12);
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic [6:0]    out_opcode;
  logic [4:0]    out_rd;
  logic [4:0]    out_rs1;
  logic [4:0]    out_rs2;
  logic [2:0]    out_funct3;
  logic [6:0]    out_funct7;
  logic [2:0]    out_fmt;
  logic [31:0]   out_imm;
  logic          out_illegal;

  modport master (
    output imem_en, imem_addr,
    input  imem_rdata,
    input  redirect_valid, redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc, out_instr, out_opcode, out_rd, out_rs1, out_rs2,
    output out_funct3, out_funct7, out_fmt, out_imm, out_illegal
  );

  modport slave (
    input  imem_en, imem_addr,
    output imem_rdata,
    output redirect_valid, redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc, out_instr, out_opcode, out_rd, out_rs1, out_rs2,
    input  out_funct3, out_funct7, out_fmt, out_imm, out_illegal
  );
endinterface

// File: rtl/fetch_decode_unit.sv
// RV32I front end: credit-limited fetch from a sync-read IMEM, prefetch FIFO of
// pre-decoded words, redirect flush and valid/ready delivery to execute.
module fetch_decode_unit #(
  parameter int          IMEM_SIZE  = 4096,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input logic            clk,
  input logic            reset,
  fetch_decode_if.master bus
);
  localparam int AW = $clog2(IMEM_SIZE);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW+1:0] DEPTH = (PW+2)'(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic        illegal;
  } entry_t;

  entry_t        fifo [FIFO_DEPTH];
  entry_t        head, dec;
  logic [PW-1:0] wp, rp;
  logic [PW:0]   count;
  logic [31:0]   fetch_pc, pc_q, instr;
  logic          inflight, pop, issue, push;
  logic [PW+1:0] credit;

  // Gated by reset so nothing is offered or popped during the reset cycle.
  assign bus.out_valid = reset && (count != '0);
  assign pop           = bus.out_valid && bus.out_ready;
  // Occupancy after this cycle's pop plus the word still in flight.
  assign credit        = (PW+2)'(count) + (PW+2)'(inflight) - (PW+2)'(pop);
  assign issue         = reset && !bus.redirect_valid && (credit < DEPTH);
  assign push          = inflight && !bus.redirect_valid;
  assign bus.imem_en   = issue;
  assign bus.imem_addr = fetch_pc[AW+1:2];
  assign instr         = bus.imem_rdata;

  always_comb begin
    dec         = '0;
    dec.pc      = pc_q;
    dec.instr   = instr;
    case (instr[6:0])
      7'b0110011: dec.fmt = 3'd0;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: begin
        dec.fmt = 3'd1;
        dec.imm = {{20{instr[31]}}, instr[31:20]};
      end
      7'b0100011: begin
        dec.fmt = 3'd2;
        dec.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      7'b1100011: begin
        dec.fmt = 3'd3;
        dec.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt = 3'd4;
        dec.imm = {instr[31:12], 12'b0};
      end
      7'b1101111: begin
        dec.fmt = 3'd5;
        dec.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: begin
        dec.fmt     = 3'd7;
        dec.illegal = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      pc_q     <= '0;
      inflight <= 1'b0;
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc_q     <= fetch_pc;
        fetch_pc <= fetch_pc + 32'd4;
      end
      // A redirect drops the FIFO and the response arriving this cycle.
      if (bus.redirect_valid) begin
        fetch_pc <= bus.redirect_pc & ~32'h3;
        wp       <= '0;
        rp       <= '0;
        count    <= '0;
      end else begin
        if (push) wp <= wp + PW'(1);
        if (pop)  rp <= rp + PW'(1);
        count <= count + (PW+1)'(push) - (PW+1)'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push) fifo[wp] <= dec;
  end

  assign head = fifo[rp];

  always_comb begin
    bus.out_pc      = '0;
    bus.out_instr   = '0;
    bus.out_opcode  = '0;
    bus.out_rd      = '0;
    bus.out_rs1     = '0;
    bus.out_rs2     = '0;
    bus.out_funct3  = '0;
    bus.out_funct7  = '0;
    bus.out_fmt     = '0;
    bus.out_imm     = '0;
    bus.out_illegal = 1'b0;
    if (bus.out_valid) begin
      bus.out_pc      = head.pc;
      bus.out_instr   = head.instr;
      bus.out_opcode  = head.instr[6:0];
      bus.out_rd      = head.instr[11:7];
      bus.out_rs1     = head.instr[19:15];
      bus.out_rs2     = head.instr[24:20];
      bus.out_funct3  = head.instr[14:12];
      bus.out_funct7  = head.instr[31:25];
      bus.out_fmt     = head.fmt;
      bus.out_imm     = head.imm;
      bus.out_illegal = head.illegal;
    end
  end
endmodule

// File: tb/tb_fetch_decode_unit.sv
// Bench for fetch_decode_unit: directed scenarios plus random ready/redirect
// traffic checked against a PC-stream model with a reference decoder.
module tb_fetch_decode_unit;
  localparam int IMEM_SIZE  = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int AW         = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_decode_if #(.AW(AW)) bus ();

  fetch_decode_unit #(.IMEM_SIZE(IMEM_SIZE), .FIFO_DEPTH(FIFO_DEPTH), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] mem [IMEM_SIZE];
  logic [31:0] exp_pc = 32'h0;

  always @(posedge clk) if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];

  function automatic logic [2:0] ref_fmt(input logic [6:0] op);
    case (op)
      7'h33:                             return 3'd0;
      7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: return 3'd1;
      7'h23:                             return 3'd2;
      7'h63:                             return 3'd3;
      7'h37, 7'h17:                      return 3'd4;
      7'h6F:                             return 3'd5;
      default:                           return 3'd7;
    endcase
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    logic signed [31:0] r;
    case (ref_fmt(w[6:0]))
      3'd1:    r = $signed(w[31:20]);
      3'd2:    r = $signed({w[31:25], w[11:7]});
      3'd3:    r = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
      3'd4:    r = {w[31:12], 12'h000};
      3'd5:    r = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
      default: r = 0;
    endcase
    return r;
  endfunction

  // Stream model: each accepted word is the next sequential PC since the last
  // reset/redirect, with IMEM content indexed modulo its size.
  always @(negedge clk) begin
    logic [31:0] w;
    logic [73:0] got, want;
    if (!reset) begin
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_valid got %b want 0", bus.out_valid);
      end
      exp_pc = 32'h0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        w = mem[(exp_pc >> 2) % IMEM_SIZE];
        checks++;
        if (bus.out_pc !== exp_pc) begin
          errors++;
          $display("FAIL stream_pc got %h want %h", bus.out_pc, exp_pc);
        end
        checks++;
        if (bus.out_instr !== w) begin
          errors++;
          $display("FAIL stream_instr got %h want %h", bus.out_instr, w);
        end
        got  = {bus.out_opcode, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_funct3,
                bus.out_funct7, bus.out_fmt, bus.out_imm, bus.out_illegal};
        want = {w[6:0], w[11:7], w[19:15], w[24:20], w[14:12], w[31:25],
                ref_fmt(w[6:0]), ref_imm(w), ref_fmt(w[6:0]) == 3'd7};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL stream_decode got %h want %h", got, want);
        end
        exp_pc = exp_pc + 32'd4;
      end
      if (bus.redirect_valid) exp_pc = bus.redirect_pc & ~32'h3;
    end
  end

  function automatic logic [31:0] rand_word();
    logic [6:0] ops [12] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F,
                              7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
    logic [31:0] w;
    w = $urandom();
    w[6:0] = ops[$urandom_range(0, 11)];
    return w;
  endfunction

  // Enter reset, load IMEM while no read is possible, leave reset next.
  task automatic do_reset(input logic ready);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.out_ready = ready;
    for (int i = 0; i < IMEM_SIZE; i++) mem[i] = rand_word();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.imem_en !== 1'b0) begin errors++; $display("FAIL rst_en got %b want 0", bus.imem_en); end
    checks++;
    if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", bus.out_pc); end
    checks++;
    if ({bus.out_instr, bus.out_imm, bus.out_fmt} !== 67'h0) begin
      errors++;
      $display("FAIL rst_fields got %h/%h/%h want 0", bus.out_instr, bus.out_imm, bus.out_fmt);
    end
  endtask

  task automatic test_first();
    int lat = -1;
    do_reset(1'b1);
    mem[0] = 32'h00500093;
    release_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (!(bus.imem_en === 1'b1 && bus.imem_addr === 4'd0)) begin
          errors++;
          $display("FAIL first_issue got en=%b addr=%0d want en=1 addr=0", bus.imem_en, bus.imem_addr);
        end
      end
      if (bus.out_valid === 1'b1 && lat < 0) begin
        lat = c;
        checks++;
        if ({bus.out_pc, bus.out_fmt, bus.out_rd, bus.out_imm} !== {32'h0, 3'd1, 5'd1, 32'd5}) begin
          errors++;
          $display("FAIL first_fields got pc=%h fmt=%0d rd=%0d imm=%h want 0/1/1/5",
                   bus.out_pc, bus.out_fmt, bus.out_rd, bus.out_imm);
        end
      end
    end
    checks++;
    if (lat != 2) begin errors++; $display("FAIL first_latency got %0d want 2", lat); end
  endtask

  task automatic test_stall();
    int issues = 0;
    int head_bad = 0;
    do_reset(1'b0);
    release_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.imem_en === 1'b1) issues++;
      if (bus.out_valid === 1'b1 && (bus.out_pc !== 32'h0 || bus.out_instr !== mem[0])) head_bad++;
    end
    checks++;
    if (issues != FIFO_DEPTH) begin errors++; $display("FAIL stall_issues got %0d want %0d", issues, FIFO_DEPTH); end
    checks++;
    if (head_bad != 0) begin errors++; $display("FAIL stall_head got %0d unstable want 0", head_bad); end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (!(bus.out_valid === 1'b1 && bus.out_pc === 32'(i * 4))) begin
        errors++;
        $display("FAIL drain_%0d got v=%b pc=%h want v=1 pc=%h", i, bus.out_valid, bus.out_pc, 32'(i * 4));
      end
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    release_reset();
    repeat (8) @(negedge clk);
    @(posedge clk); #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h43;
    @(negedge clk);
    checks++;
    if (bus.imem_en !== 1'b0) begin errors++; $display("FAIL redir_en got %b want 0", bus.imem_en); end
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (!(bus.imem_en === 1'b1 && bus.imem_addr === 4'd0 && bus.out_valid === 1'b0)) begin
      errors++;
      $display("FAIL redir_n1 got en=%b addr=%0d v=%b want 1/0/0", bus.imem_en, bus.imem_addr, bus.out_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL redir_n2 got v=%b want 0", bus.out_valid); end
    @(negedge clk);
    checks++;
    if (!(bus.out_valid === 1'b1 && bus.out_pc === 32'h40)) begin
      errors++;
      $display("FAIL redir_n3 got v=%b pc=%h want v=1 pc=40", bus.out_valid, bus.out_pc);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_decode();
    int c = 0;
    do_reset(1'b1);
    mem[0] = 32'hFE000CE3;
    mem[1] = 32'h0000007F;
    release_reset();
    @(negedge clk);
    while (bus.out_valid !== 1'b1 && c < 10) begin @(negedge clk); c++; end
    checks++;
    if (!(bus.out_valid === 1'b1 && bus.out_fmt === 3'd3 && bus.out_imm === 32'hFFFFFFF8 && bus.out_illegal === 1'b0)) begin
      errors++;
      $display("FAIL dec_branch got v=%b fmt=%0d imm=%h ill=%b want 1/3/fffffff8/0",
               bus.out_valid, bus.out_fmt, bus.out_imm, bus.out_illegal);
    end
    @(negedge clk);
    checks++;
    if (!(bus.out_illegal === 1'b1 && bus.out_fmt === 3'd7 && bus.out_imm === 32'h0 && bus.out_instr === 32'h7F)) begin
      errors++;
      $display("FAIL dec_illegal got ill=%b fmt=%0d imm=%h instr=%h want 1/7/0/7f",
               bus.out_illegal, bus.out_fmt, bus.out_imm, bus.out_instr);
    end
  endtask

  task automatic test_wrap();
    logic [3:0]  addrs [4];
    logic [31:0] pcs [4];
    logic [3:0]  exp_a [4] = '{4'd14, 4'd15, 4'd0, 4'd1};
    logic [31:0] exp_p [4] = '{32'h38, 32'h3C, 32'h40, 32'h44};
    int na = 0;
    int np = 0;
    do_reset(1'b1);
    release_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h38;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.imem_en === 1'b1 && na < 4) begin addrs[na] = bus.imem_addr; na++; end
      if (bus.out_valid === 1'b1 && np < 4) begin pcs[np] = bus.out_pc; np++; end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= na || addrs[i] !== exp_a[i]) begin
        errors++;
        $display("FAIL wrap_addr_%0d got %0d (n=%0d) want %0d", i, addrs[i], na, exp_a[i]);
      end
      checks++;
      if (i >= np || pcs[i] !== exp_p[i]) begin
        errors++;
        $display("FAIL wrap_pc_%0d got %h (n=%0d) want %h", i, pcs[i], np, exp_p[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b1);
    release_reset();
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (!(bus.out_valid === 1'b0 && bus.imem_en === 1'b0)) begin
      errors++;
      $display("FAIL midrst_cycle got v=%b en=%b want 0/0", bus.out_valid, bus.imem_en);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (c < 2 && bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midrst_c%0d got v=%b want 0", c, bus.out_valid);
      end else if (c == 2 && !(bus.out_valid === 1'b1 && bus.out_pc === 32'h0)) begin
        errors++;
        $display("FAIL midrst_refetch got v=%b pc=%h want v=1 pc=0", bus.out_valid, bus.out_pc);
      end
    end
  endtask

  task automatic test_random();
    int pops = 0;
    do_reset(1'b1);
    release_reset();
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, 19) == 0);
      bus.redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF6 : $urandom();
      @(negedge clk);
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) pops++;
    end
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    checks++;
    if (pops < 100) begin errors++; $display("FAIL random_progress got %0d pops want >= 100", pops); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first();
    test_stall();
    test_redirect();
    test_decode();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
